// File: rtl/tpi_par_rx.sv
// Receive-side parallel handshake for the tri-port interface: synchronises the host DAV
// strobe, captures the port A byte into a first-word-fall-through FIFO and answers with ACK.
module tpi_par_rx #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clock,
    input  logic                     _reset,
    input  logic [7:0]               pa_in,
    input  logic                     dav,
    output logic                     ack,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err,
    input  logic                     clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_ACKED      = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   dav_s;
    state_t                 state_r;
    logic                   ack_r;
    logic                   proto_err_r;
    logic [7:0]             mem_r [DEPTH];
    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic                   full_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   set_err_s;

    assign dav_s     = sync_r[SYNC_STAGES-1];
    assign full_s    = (count_r == CW'(DEPTH));
    assign pop_s     = (count_r != {CW{1'b0}}) && rx_ready;

    assign ack       = ack_r;
    assign proto_err = proto_err_r;
    assign count     = count_r;
    assign rx_valid  = (count_r != {CW{1'b0}});
    assign rx_data   = mem_r[rd_ptr_r];

    // Push and error-set decisions; full is judged on the pre-pop occupancy.
    always_comb begin
        push_s    = 1'b0;
        set_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dav_s && !full_s) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            ST_WAIT_SPACE: begin
                if (!dav_s) begin
                    set_err_s = 1'b1;
                end else if (!full_s) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            default: begin
                push_s    = 1'b0;
                set_err_s = 1'b0;
            end
        endcase
    end

    // DAV synchroniser chain; raw dav is read nowhere else.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], dav};
        end
    end

    // Handshake FSM with registered ack and sticky error flag.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            state_r     <= ST_IDLE;
            ack_r       <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dav_s && !full_s) begin
                        ack_r   <= 1'b1;
                        state_r <= ST_ACKED;
                    end else if (dav_s) begin
                        ack_r   <= 1'b0;
                        state_r <= ST_WAIT_SPACE;
                    end else begin
                        ack_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_SPACE: begin
                    if (!dav_s) begin
                        ack_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (!full_s) begin
                        ack_r   <= 1'b1;
                        state_r <= ST_ACKED;
                    end else begin
                        ack_r   <= 1'b0;
                        state_r <= ST_WAIT_SPACE;
                    end
                end
                ST_ACKED: begin
                    if (!dav_s) begin
                        ack_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        ack_r   <= 1'b1;
                        state_r <= ST_ACKED;
                    end
                end
                default: begin
                    ack_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase

            // A new abort outranks a same-cycle clear.
            if (set_err_s) begin
                proto_err_r <= 1'b1;
            end else if (clr_err) begin
                proto_err_r <= 1'b0;
            end else begin
                proto_err_r <= proto_err_r;
            end
        end
    end

    // FIFO storage and pointers; pointer widths make the wrap modulo DEPTH.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= pa_in;
                wr_ptr_r        <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
